// File: rtl/if_fetch_stage.sv
// Instruction Fetch stage: owns the PC, runs the instruction-memory
// request handshake and drives the IF/ID pipeline register. Sequences PC+4,
// redirects to a branch target once the delay slot has been handed over,
// applies exception vectors, and buffers a returned word while ID is stalled.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ID_Stall,
  input  logic        ID_IsBranch,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  input  logic        Exc_Redirect,
  input  logic [31:0] Exc_Vector,
  output logic        IMem_Req,
  output logic [29:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_RData,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCAdd4,
  output logic        IF_IsBDS,
  output logic        IF_Stall
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] br_target_q;
  logic        br_pend_q;
  logic        bds_pend_q;
  logic [31:0] exc_vec_q;
  // Cleared by reset, set on the first rising edge after release so that
  // fetching begins one edge after reset deasserts.
  logic        run_q;

  logic        avail_s;
  logic        advance_s;
  logic [31:0] pc_add4_s;
  logic [31:0] next_pc_d;

  // Availability of a word for ID and the advance condition.
  always_comb begin
    avail_s = 1'b0;
    case (state_q)
      S_FETCH:   avail_s = run_q & IMem_Ready;
      S_HOLD:    avail_s = 1'b1;
      S_DISCARD: avail_s = 1'b0;
      default:   avail_s = 1'b0;
    endcase
    advance_s = avail_s & ~ID_Stall;
  end

  // Next PC selection: exception, live branch, pending branch, sequential.
  always_comb begin
    pc_add4_s = pc_q + 32'd4;
    next_pc_d = pc_add4_s;
    if (Exc_Redirect) begin
      next_pc_d = Exc_Vector;
    end else if (Br_Taken) begin
      next_pc_d = Br_Target;
    end else if (br_pend_q) begin
      next_pc_d = br_target_q;
    end else begin
      next_pc_d = pc_add4_s;
    end
  end

  // Output decode; outputs fall to idle values immediately on reset since
  // run_q is cleared asynchronously.
  always_comb begin
    IMem_Req       = run_q & (state_q != S_HOLD);
    IMem_Addr      = pc_q[31:2];
    IF_PC          = pc_q;
    IF_PCAdd4      = pc_add4_s;
    IF_Stall       = ~avail_s;
    IF_IsBDS       = avail_s & (ID_IsBranch | bds_pend_q);
    IF_Instruction = 32'h0000_0000;
    if (!avail_s) begin
      IF_Instruction = 32'h0000_0000;
    end else if (state_q == S_HOLD) begin
      IF_Instruction = buf_q;
    end else begin
      IF_Instruction = IMem_RData;
    end
  end

  // Fetch FSM, PC, hold buffer and pending branch/delay-slot bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_VECTOR;
      buf_q       <= 32'h0000_0000;
      br_target_q <= 32'h0000_0000;
      br_pend_q   <= 1'b0;
      bds_pend_q  <= 1'b0;
      exc_vec_q   <= 32'h0000_0000;
      run_q       <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else if (Exc_Redirect) begin
      br_pend_q  <= 1'b0;
      bds_pend_q <= 1'b0;
      if ((state_q != S_HOLD) && !IMem_Ready) begin
        // Request still outstanding: keep the address stable, drop the
        // returning word and redirect once the memory completes.
        exc_vec_q <= Exc_Vector;
        state_q   <= S_DISCARD;
      end else begin
        pc_q    <= Exc_Vector;
        state_q <= S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (IMem_Ready && ID_Stall) begin
            buf_q   <= IMem_RData;
            state_q <= S_HOLD;
          end else if (IMem_Ready) begin
            pc_q    <= next_pc_d;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (!ID_Stall) begin
            pc_q    <= next_pc_d;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_HOLD;
          end
        end
        S_DISCARD: begin
          if (IMem_Ready) begin
            pc_q    <= exc_vec_q;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_DISCARD;
          end
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase

      if (advance_s) begin
        br_pend_q  <= 1'b0;
        bds_pend_q <= 1'b0;
      end else begin
        if (Br_Taken) begin
          br_target_q <= Br_Target;
          br_pend_q   <= 1'b1;
        end
        // Branch leaves ID while its delay slot is still being fetched.
        if (ID_IsBranch && !ID_Stall) begin
          bds_pend_q <= 1'b1;
        end
      end
    end
  end

endmodule
